// File: rtl/video_pkg.sv
// Shared types and mode encodings for the scanline video stage.
// Combinational definitions only; no clocking or backpressure involved.
package video_pkg;

  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_25  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_75  = 2'd3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic hs;
    logic vs;
    logic de;
  } vid_t;

endpackage

// File: rtl/video_scanlines_if.sv
// Video stream in/out plus per-frame scanline settings for video_scanlines.
// The source side drives the master modport; the scanline stage sits on the slave modport.
interface video_scanlines_if #(
  parameter int PERIOD_W = 2
);
  logic [1:0]          sl_mode;
  logic [PERIOD_W-1:0] sl_period;
  logic [PERIOD_W-1:0] sl_phase;
  logic [23:0]         din;
  logic                hs_in;
  logic                vs_in;
  logic                de_in;
  logic [23:0]         dout;
  logic                hs_out;
  logic                vs_out;
  logic                de_out;

  modport master (
    output sl_mode, sl_period, sl_phase, din, hs_in, vs_in, de_in,
    input  dout, hs_out, vs_out, de_out
  );

  modport slave (
    input  sl_mode, sl_period, sl_phase, din, hs_in, vs_in, de_in,
    output dout, hs_out, vs_out, de_out
  );
endinterface

// File: rtl/video_scanline_dim.sv
// Per-channel scanline dimming: scales an 8-bit value by 3/4, 1/2 or 1/4.
// Purely combinational; no backpressure.
module video_scanline_dim
  import video_pkg::*;
(
  input  logic [7:0] x,
  input  logic [1:0] mode,
  output logic [7:0] y
);

  always_comb begin
    y = x;
    case (mode)
      SL_25:   y = x - (x >> 2);
      SL_50:   y = x >> 1;
      SL_75:   y = x >> 2;
      default: y = x;
    endcase
  end

endmodule

// File: rtl/video_scanlines.sv
// CRT scanline emulation: dims selected raster lines, pattern locked to sync edges.
// Latency: LATENCY clk_vid cycles for video and syncs alike; free-running, no backpressure.
module video_scanlines
  import video_pkg::*;
#(
  parameter int PERIOD_W = 2,
  parameter int LATENCY  = 3
) (
  input  logic         clk_vid,
  input  logic         reset_n,
  video_scanlines_if.slave vid
);

  localparam int TAIL = LATENCY - 2;

  logic                old_hs;
  logic                old_vs;
  logic                line_had_de;
  logic [PERIOD_W-1:0] line_cnt;
  logic [1:0]          mode_l;
  logic [PERIOD_W-1:0] period_l;
  logic [PERIOD_W-1:0] phase_l;

  logic hs_fall;
  logic vs_fall;
  logic dim_line;

  assign hs_fall = old_hs & ~vid.hs_in;
  assign vs_fall = old_vs & ~vid.vs_in;

  // Settings only move on the VS falling edge, so a frame never mixes two modes.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      old_hs      <= 1'b0;
      old_vs      <= 1'b0;
      line_had_de <= 1'b0;
      line_cnt    <= '0;
      mode_l      <= SL_OFF;
      period_l    <= '0;
      phase_l     <= '0;
    end else begin
      old_hs <= vid.hs_in;
      old_vs <= vid.vs_in;
      if (vs_fall) begin
        mode_l      <= vid.sl_mode;
        period_l    <= vid.sl_period;
        phase_l     <= vid.sl_phase;
        line_cnt    <= '0;
        line_had_de <= 1'b0;
      end else if (hs_fall) begin
        if (line_had_de) begin
          line_cnt <= (line_cnt == period_l) ? '0 : line_cnt + 1'b1;
        end
        line_had_de <= 1'b0;
      end else if (vid.de_in) begin
        line_had_de <= 1'b1;
      end
    end
  end

  // Period 0 pins line_cnt at 0, so the period test is what makes every line dim.
  assign dim_line = (mode_l != SL_OFF) && ((period_l == '0) || (line_cnt != phase_l));

  vid_t       s1;
  vid_t       s2;
  logic [1:0] m1;
  logic [1:0] m2;
  logic [7:0] dim_r;
  logic [7:0] dim_g;
  logic [7:0] dim_b;
  vid_t       tail [TAIL];

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      m1 <= SL_OFF;
      m2 <= SL_OFF;
    end else begin
      s1.rgb <= rgb_t'(vid.din);
      s1.hs  <= vid.hs_in;
      s1.vs  <= vid.vs_in;
      s1.de  <= vid.de_in;
      m1     <= dim_line ? mode_l : SL_OFF;
      s2     <= s1;
      m2     <= m1;
    end
  end

  video_scanline_dim u_dim_r (.x(s2.rgb.r), .mode(m2), .y(dim_r));
  video_scanline_dim u_dim_g (.x(s2.rgb.g), .mode(m2), .y(dim_g));
  video_scanline_dim u_dim_b (.x(s2.rgb.b), .mode(m2), .y(dim_b));

  // tail[0] is the final arithmetic stage; any further entries are plain delay.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAIL; i++) begin
        tail[i] <= '0;
      end
    end else begin
      tail[0].rgb <= '{r: dim_r, g: dim_g, b: dim_b};
      tail[0].hs  <= s2.hs;
      tail[0].vs  <= s2.vs;
      tail[0].de  <= s2.de;
      for (int i = 1; i < TAIL; i++) begin
        tail[i] <= tail[i-1];
      end
    end
  end

  assign vid.dout   = tail[TAIL-1].rgb;
  assign vid.hs_out = tail[TAIL-1].hs;
  assign vid.vs_out = tail[TAIL-1].vs;
  assign vid.de_out = tail[TAIL-1].de;

endmodule

// File: tb/tb_video_scanlines.sv
// Directed bench for video_scanlines: latency, dim arithmetic, line/frame tracking, reset.
module tb_video_scanlines;
  import video_pkg::*;

  logic clk_vid = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_vid = ~clk_vid;

  video_scanlines_if #(.PERIOD_W(2)) vif ();

  video_scanlines #(.PERIOD_W(2), .LATENCY(3)) dut (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .vid     (vif.slave)
  );

  task automatic tick;
    @(posedge clk_vid);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de, input logic [23:0] pix);
    vif.hs_in = hs;
    vif.vs_in = vs;
    vif.de_in = de;
    vif.din   = pix;
  endtask

  task automatic set_mode(input logic [1:0] mode, input logic [1:0] period, input logic [1:0] phase);
    vif.sl_mode   = mode;
    vif.sl_period = period;
    vif.sl_phase  = phase;
  endtask

  // HS pulse, back porch, four pixels (active or blank), front porch.
  task automatic line(input logic [23:0] pix, input bit act, input logic [23:0] exp, input string tag);
    drive(1'b1, 1'b0, 1'b0, 24'h0); tick; tick;
    drive(1'b0, 1'b0, 1'b0, 24'h0); tick; tick;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, act, pix);
      tick;
      if (act && i == 2) begin
        chk(tag, vif.dout, exp);
        chk({tag, "_de"}, {23'd0, vif.de_out}, 24'd1);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 24'h0); tick; tick; tick;
  endtask

  task automatic vsync;
    drive(1'b0, 1'b1, 1'b0, 24'h0); tick; tick; tick;
    drive(1'b0, 1'b0, 1'b0, 24'h0); tick; tick;
  endtask

  initial begin
    set_mode(SL_OFF, 2'd0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick; tick;
    chk("rst_dout", vif.dout, 24'h0);
    chk("rst_sync", {21'd0, vif.hs_out, vif.vs_out, vif.de_out}, 24'd0);

    // Latency: pass-through with mode 0, value shows up on the third edge.
    reset_n = 1'b1;
    tick;
    drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    tick;
    chk("lat_c1", vif.dout, 24'h0);
    tick;
    chk("lat_c2", vif.dout, 24'h0);
    chk("lat_c2_sync", {21'd0, vif.hs_out, vif.vs_out, vif.de_out}, 24'd0);
    tick;
    chk("lat_c3", vif.dout, 24'hFFFFFF);
    chk("lat_c3_sync", {21'd0, vif.hs_out, vif.vs_out, vif.de_out}, 24'd7);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick; tick; tick; tick;

    // 50% on alternate lines.
    set_mode(SL_50, 2'd1, 2'd0);
    vsync();
    line(24'h804020, 1'b1, 24'h804020, "alt_l0");
    line(24'h804020, 1'b1, 24'h402010, "alt_l1");
    line(24'h804020, 1'b1, 24'h804020, "alt_l2");
    line(24'h804020, 1'b1, 24'h402010, "alt_l3");

    // Blank lines between active lines must not step the pattern.
    line(24'h804020, 1'b1, 24'h804020, "blank_l4");
    line(24'h0, 1'b0, 24'h0, "blank_a");
    line(24'h0, 1'b0, 24'h0, "blank_b");
    line(24'h0, 1'b0, 24'h0, "blank_c");
    line(24'h804020, 1'b1, 24'h402010, "blank_l5");
    line(24'h804020, 1'b1, 24'h804020, "blank_l6");

    // New settings ignored until the VS fall.
    set_mode(SL_25, 2'd0, 2'd0);
    line(24'hFFFFFF, 1'b1, 24'h7F7F7F, "hold_old");
    vsync();
    line(24'hFFFFFF, 1'b1, 24'hC0C0C0, "m25_ff");
    line(24'h070707, 1'b1, 24'h060606, "m25_07");
    set_mode(SL_75, 2'd0, 2'd0);
    vsync();
    line(24'h070707, 1'b1, 24'h010101, "m75_07");
    line(24'h804020, 1'b1, 24'h201008, "m75_mix");

    // Mode 0 -> 3 mid-frame.
    set_mode(SL_OFF, 2'd0, 2'd0);
    vsync();
    line(24'hFFFFFF, 1'b1, 24'hFFFFFF, "off_l0");
    set_mode(SL_75, 2'd1, 2'd1);
    line(24'hFFFFFF, 1'b1, 24'hFFFFFF, "mid_chg");
    vsync();
    line(24'hFFFFFF, 1'b1, 24'h3F3F3F, "ph1_l0");
    line(24'hFFFFFF, 1'b1, 24'hFFFFFF, "ph1_l1");
    line(24'hFFFFFF, 1'b1, 24'h3F3F3F, "ph1_l2");

    // Phase beyond period: every line dims.
    set_mode(SL_50, 2'd2, 2'd3);
    vsync();
    line(24'hFFFFFF, 1'b1, 24'h7F7F7F, "phgt_l0");
    line(24'hFFFFFF, 1'b1, 24'h7F7F7F, "phgt_l1");
    line(24'hFFFFFF, 1'b1, 24'h7F7F7F, "phgt_l2");

    // Reset mid-line: outputs clear at once, then pass-through until next VS fall.
    drive(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    tick; tick; tick; tick;
    chk("pre_rst", vif.dout, 24'h7F7F7F);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_dout", vif.dout, 24'h0);
    chk("async_rst_sync", {21'd0, vif.hs_out, vif.vs_out, vif.de_out}, 24'd0);
    tick;
    reset_n = 1'b1;
    tick; tick; tick;
    chk("post_rst", vif.dout, 24'hFFFFFF);
    chk("post_rst_de", {23'd0, vif.de_out}, 24'd1);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick; tick; tick;
    line(24'hFFFFFF, 1'b1, 24'hFFFFFF, "post_rst_line");
    vsync();
    line(24'hFFFFFF, 1'b1, 24'h7F7F7F, "relatch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
